// File: rtl/ram_access_unit.sv
`timescale 1ns/1ps
// ram_access_unit
//
// Initiator for one port of a dual-port byte-enable RAM. Takes byte-addressed
// load/store requests, performs them as one or two word beats on the RAM port
// (two when the access straddles a word boundary), and returns sign/zero
// extended load data on the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side is only ready in IDLE; the response side holds
// rsp_valid/rsp_rdata/rsp_err stable until rsp_ready is seen. Only one access
// is outstanding at a time.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_addr                byte address
//   req_wdata               store data, right-aligned
//   req_we                  1 = store, 0 = load
//   req_size                00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned            1 = zero-extend loads
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               extended load data (0 for stores and errors)
//   rsp_err                 access rejected
//   ram_addr/din/dout/en/we RAM port; ram_dout valid the cycle after ram_en
//   dbg_state               current FSM state, for checkers
module ram_access_unit #(
    parameter int RAM_DEPTH = 16384,
    parameter int COL_WIDTH = 8,
    parameter int COL_NUM   = 4,
    parameter int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic                          req_we,
    input  logic [1:0]                    req_size,
    input  logic                          req_unsigned,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic [AW-1:0]                 ram_addr,
    output logic [COL_WIDTH*COL_NUM-1:0]  ram_din,
    input  logic [COL_WIDTH*COL_NUM-1:0]  ram_dout,
    output logic                          ram_en,
    output logic [COL_NUM-1:0]            ram_we,
    output logic [2:0]                    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_DATA  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [31:0]   DEPTH_U  = 32'(RAM_DEPTH);
    localparam logic [AW-1:0] WORD_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic          uns_q, uns_d;
    logic          split_q, split_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   beat0_q, beat0_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    // Request decode (only meaningful in IDLE)
    logic [2:0]    req_n;
    logic          req_split;
    logic          req_err;
    logic [31:0]   req_word;

    always_comb begin
        req_word = {2'b00, req_addr[31:2]};
        case (req_size)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
        req_split = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
        // The second beat must also be inside the RAM: addresses never wrap.
        req_err   = (req_size == 2'b11) ||
                    (req_word >= DEPTH_U) ||
                    (req_split && (req_word >= (DEPTH_U - 32'd1)));
    end

    // Store data and byte mask spread across two words: the low word is
    // beat 0, the high word is beat 1.
    logic [63:0] st_data;
    logic [7:0]  st_mask;
    logic [3:0]  size_mask;

    always_comb begin
        case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        st_data = {32'b0, wdata_q} << {off_q, 3'b000};
        st_mask = {4'b0000, size_mask} << off_q;
    end

    // Load result: the byte window starting at off inside {beat1, beat0}.
    // In DATA, ram_dout carries the last beat issued.
    logic [63:0] ld_raw;
    logic [31:0] ld_lo;
    logic [31:0] ld_result;

    always_comb begin
        ld_raw = split_q ? {ram_dout, beat0_q} : {32'b0, ram_dout};
        ld_lo  = 32'(ld_raw >> {off_q, 3'b000});
        case (size_q)
            2'b00:   ld_result = uns_q ? {24'b0, ld_lo[7:0]}
                                       : {{24{ld_lo[7]}}, ld_lo[7:0]};
            2'b01:   ld_result = uns_q ? {16'b0, ld_lo[15:0]}
                                       : {{16{ld_lo[15]}}, ld_lo[15:0]};
            default: ld_result = ld_lo;
        endcase
    end

    // Next state and outputs
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        off_d       = off_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        beat0_d     = beat0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        ram_en      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        ram_we      = '0;

        case (state_q)
            S_IDLE: begin
                // Held low during reset so nothing is seen as accepted.
                req_ready = reset_n;
                if (req_valid && req_ready) begin
                    word_d  = req_addr[AW+1:2];
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    split_d = req_split;
                    wdata_d = req_wdata;
                    if (req_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'b0;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_BEAT0;
                    end
                end
            end

            S_BEAT0: begin
                ram_en   = 1'b1;
                ram_addr = word_q;
                if (we_q) begin
                    ram_din = st_data[31:0];
                    ram_we  = st_mask[3:0];
                end
                if (split_q) begin
                    state_d = S_BEAT1;
                end else if (we_q) begin
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_BEAT1: begin
                ram_en   = 1'b1;
                ram_addr = word_q + WORD_ONE;
                if (we_q) begin
                    ram_din     = st_data[63:32];
                    ram_we      = st_mask[7:4];
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else begin
                    // Beat-0 read data is on ram_dout now.
                    beat0_d = ram_dout;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                rsp_rdata_d = ld_result;
                rsp_err_d   = 1'b0;
                state_d     = S_RESP;
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_rdata_d = 32'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            off_q       <= 2'b0;
            size_q      <= 2'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            wdata_q     <= 32'b0;
            beat0_q     <= 32'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            off_q       <= off_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            beat0_q     <= beat0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_access_unit.sv
`timescale 1ns/1ps
// Testbench for ram_access_unit: behavioural RAM on the port, byte-level
// reference model of memory contents, directed steps plus random requests.
module tb_ram_access_unit;

    localparam int RAM_DEPTH = 16384;
    localparam int AW        = $clog2(RAM_DEPTH);

    // Clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [2:0]    dbg_state;

    ram_access_unit #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_en(ram_en), .ram_we(ram_we), .dbg_state(dbg_state)
    );

    // Behavioural byte-enable RAM: read returns old contents one cycle later.
    logic [31:0] mem [RAM_DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
        end
    end

    // Beat log, sampled away from the active edge
    logic [31:0] bt_addr[$];
    logic [31:0] bt_we[$];
    logic [31:0] bt_din[$];
    always @(negedge clk) begin
        if (ram_en) begin
            bt_addr.push_back(32'(ram_addr));
            bt_we.push_back({28'b0, ram_we});
            bt_din.push_back(ram_din);
        end
    end

    // Reference memory as individual bytes
    logic [7:0] ref_bytes [int unsigned];

    function automatic logic [7:0] ref_rd(input int unsigned a);
        return ref_bytes.exists(a) ? ref_bytes[a] : 8'h00;
    endfunction

    task automatic preload(input int unsigned word, input logic [31:0] val);
        mem[word] = val;
        for (int b = 0; b < 4; b++) ref_bytes[word*4 + b] = val[8*b +: 8];
    endtask

    // Scoreboard counters and compare point
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_garbage();
        req_valid    = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
    endtask

    // One complete access with all checks derived from the reference model
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [1:0] size, input logic uns,
                          input int hold, output logic [31:0] obs_rdata);
        int unsigned n, off, word, ba;
        int          lat_exp, cyc, nbeats;
        logic        err, split;
        logic [31:0] exp_rdata, exp_we, exp_din, lane_mask;

        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off   = 32'(addr[1:0]);
        word  = addr >> 2;
        split = (off + n) > 4;
        err   = (size == 2'b11) || (word >= RAM_DEPTH) ||
                (split && (word + 1 >= RAM_DEPTH));

        exp_rdata = 32'b0;
        if (!err && !we) begin
            for (int i = 0; i < int'(n); i++) exp_rdata[8*i +: 8] = ref_rd(addr + i);
            if (!uns && n < 4 && exp_rdata[8*n-1])
                for (int i = 8*n; i < 32; i++) exp_rdata[i] = 1'b1;
        end
        lat_exp = err ? 1 : we ? (split ? 3 : 2) : (split ? 4 : 3);
        nbeats  = err ? 0 : (split ? 2 : 1);

        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata;
        req_we = we; req_size = size; req_unsigned = uns;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("accept_ready", 64'(req_ready), 64'd1);
        bt_addr.delete(); bt_we.delete(); bt_din.delete();

        @(negedge clk);
        cyc = 1;
        drive_garbage();
        while (!rsp_valid && cyc < 12) begin @(negedge clk); cyc++; drive_garbage(); end
        chk("rsp_latency", 64'(cyc), 64'(lat_exp));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        obs_rdata = rsp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive_garbage();
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_hs", 64'(req_ready), 64'd1);
        chk("rsp_valid_after_hs", 64'(rsp_valid), 64'd0);

        chk("beat_count", 64'(bt_addr.size()), 64'(nbeats));
        if (bt_addr.size() == nbeats) begin
            for (int k = 0; k < nbeats; k++) begin
                exp_we = 32'b0; exp_din = 32'b0; lane_mask = 32'b0;
                for (int b = 0; b < 4; b++) begin
                    ba = (word + k) * 4 + b;
                    if (we && ba >= addr && ba < addr + n) begin
                        exp_we[b]          = 1'b1;
                        lane_mask[8*b +: 8] = 8'hFF;
                        exp_din[8*b +: 8]   = wdata[8*(ba - addr) +: 8];
                    end
                end
                chk("beat_addr", 64'(bt_addr[k]), 64'((word + k) % RAM_DEPTH));
                chk("beat_we", 64'(bt_we[k]), 64'(exp_we));
                chk("beat_din", 64'(bt_din[k] & lane_mask), 64'(exp_din));
            end
        end

        if (!err && we)
            for (int i = 0; i < int'(n); i++) ref_bytes[addr + i] = wdata[8*i +: 8];
    endtask

    logic [31:0] rd;
    logic [31:0] rnd_addr, rnd_wdata;
    logic [1:0]  rnd_size;

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'b0;
        req_valid = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
        req_we = 1'b0; req_size = 2'b0; req_unsigned = 1'b0; rsp_ready = 1'b0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_din", 64'(ram_din), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_release_ready", 64'(req_ready), 64'd1);

        // Aligned word store then load
        do_req(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 0, rd);
        chk("aligned_st_addr", 64'(bt_addr.size() > 0 ? bt_addr[0] : 32'hFFFF_FFFF), 64'd4);
        chk("aligned_st_we", 64'(bt_we.size() > 0 ? bt_we[0] : 32'hFFFF_FFFF), 64'hF);
        do_req(32'h10, 32'h0, 1'b0, 2'b10, 1'b0, 0, rd);
        chk("aligned_ld_const", 64'(rd), 64'hDEADBEEF);

        // Byte load, signed and unsigned
        preload(4, 32'h80FF_1234);
        do_req(32'h13, 32'h0, 1'b0, 2'b00, 1'b0, 0, rd);
        chk("byte_signed_const", 64'(rd), 64'hFFFF_FF80);
        do_req(32'h13, 32'h0, 1'b0, 2'b00, 1'b1, 0, rd);
        chk("byte_unsigned_const", 64'(rd), 64'h0000_0080);

        // Misaligned word store and load back
        do_req(32'h6, 32'h11223344, 1'b1, 2'b10, 1'b0, 0, rd);
        chk("misal_b0_addr", 64'(bt_addr.size() > 1 ? bt_addr[0] : 32'hFFFF_FFFF), 64'd1);
        chk("misal_b0_we", 64'(bt_we.size() > 1 ? bt_we[0] : 32'hFFFF_FFFF), 64'hC);
        chk("misal_b0_din", 64'(bt_din.size() > 1 ? bt_din[0][31:16] : 16'hFFFF), 64'h3344);
        chk("misal_b1_addr", 64'(bt_addr.size() > 1 ? bt_addr[1] : 32'hFFFF_FFFF), 64'd2);
        chk("misal_b1_we", 64'(bt_we.size() > 1 ? bt_we[1] : 32'hFFFF_FFFF), 64'h3);
        chk("misal_b1_din", 64'(bt_din.size() > 1 ? bt_din[1][15:0] : 16'hFFFF), 64'h1122);
        do_req(32'h6, 32'h0, 1'b0, 2'b10, 1'b0, 0, rd);
        chk("misal_ld_const", 64'(rd), 64'h11223344);

        // Error cases
        do_req(32'h20, 32'h5555_5555, 1'b1, 2'b11, 1'b0, 0, rd);
        do_req(32'(RAM_DEPTH * 4), 32'h0, 1'b0, 2'b10, 1'b0, 0, rd);
        do_req(32'(RAM_DEPTH * 4 - 2), 32'hAAAA_AAAA, 1'b1, 2'b10, 1'b0, 0, rd);
        // Last legal word, and a half that straddles past the end
        do_req(32'(RAM_DEPTH * 4 - 4), 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0, 0, rd);
        do_req(32'(RAM_DEPTH * 4 - 1), 32'h0, 1'b0, 2'b01, 1'b0, 0, rd);

        // Stalled response
        do_req(32'h10, 32'h0, 1'b0, 2'b01, 1'b0, 5, rd);

        // Reset during BEAT0 of a split store
        preload(10, 32'h0BAD_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h26; req_wdata = 32'hA1B2C3D4;
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        chk("mid_rst_accept_ready", 64'(req_ready), 64'd1);
        bt_addr.delete(); bt_we.delete(); bt_din.delete();
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_beat0_en", 64'(ram_en), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready_low", 64'(req_ready), 64'd0);
        chk("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);
        chk("mid_rst_no_beat1", 64'(ram_en), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_ready_release", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("mid_rst_no_rsp_after", 64'(rsp_valid), 64'd0);
        chk("mid_rst_beat_count", 64'(bt_addr.size()), 64'd1);
        ref_bytes[32'h26] = 8'hD4;
        ref_bytes[32'h27] = 8'hC3;
        do_req(32'h24, 32'h0, 1'b0, 2'b10, 1'b0, 0, rd);
        do_req(32'h28, 32'h0, 1'b0, 2'b10, 1'b0, 0, rd);

        // Random traffic against the reference model
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 9) < 8) rnd_addr = 32'($urandom_range(0, 63));
            else rnd_addr = 32'($urandom_range(RAM_DEPTH * 4 - 8, RAM_DEPTH * 4 + 7));
            rnd_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rnd_wdata = $urandom;
            do_req(rnd_addr, rnd_wdata, 1'($urandom_range(0, 1)), rnd_size,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
